coax_line_frontend: RTL and testbench
=====================================

Name: coax_line_frontend

Overview:
- Multi-channel coax line front end between pad I/O and the buffered coax TX/RX cores.
- Per channel:
  - synchronises and deglitches the RX pin;
  - blanks RX during transmit and for a programmable turnaround guard afterwards;
  - selects internal loopback;
  - gates TX active toward the distorter.
- Aggregates per-channel RX activity/error into a maskable interrupt.
- Replaces the fixed two-flop, single-channel glue.

Parameters:
- CHANNELS, 1, number of independent coax channels.
- SYNC_STAGES, 2, RX synchroniser depth (min 2).
- FILTER_LENGTH, 3, consecutive identical samples required to accept an RX level change (min 1).
- TURNAROUND_CLOCKS, 32, RX blanking cycles after TX active falls (0 = no guard).

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- rx_pin  input  CHANNELS  raw RX from pad (already through I/O cell).
- tx_internal  input  CHANNELS  serial TX from coax_buffered_tx.
- tx_internal_active  input  CHANNELS  TX active from coax_buffered_tx.
- loopback  input  CHANNELS  loopback select from control.
- rx_to_core  output  CHANNELS  RX feed to coax_buffered_rx.
- tx_active_out  output  CHANNELS  active to coax_tx_distorter.
- rx_core_active  input  CHANNELS  RX core active.
- rx_core_error  input  CHANNELS  RX core error.
- irq_mask  input  CHANNELS  1 = channel masked from irq.
- irq_clear  input  CHANNELS  per-channel status clear strobe.
- irq_status  output  CHANNELS  per-channel interrupt status.
- irq  output  1  interrupt request.

Behaviour:
- All channels are identical and independent; only irq is shared.
- Reset (async assert, sync release) sets:
  - sync chains 0, filter outputs 0, filter counters 0;
  - state LISTEN, guard counter 0;
  - rx_to_core 0, irq_status 0, irq 0.
- Reset mid-frame returns to LISTEN immediately; there is no guard after reset.
- Synchroniser: SYNC_STAGES flops from rx_pin.
- Filter:
  - counter width clog2(FILTER_LENGTH)+1.
  - synced sample == filtered output → counter cleared.
  - Otherwise counter increments; on the FILTER_LENGTH-th consecutive differing sample, the filtered output takes the sample and the counter clears.
  - Pulses shorter than FILTER_LENGTH cycles never propagate.
- Pin-to-filtered latency for a stable edge: SYNC_STAGES+FILTER_LENGTH cycles.
- tx_active_out = tx_internal_active & ~loopback, combinational, so it stays aligned with tx_internal.
- rx_to_core is registered from the state mux (1 cycle).
- Channel FSM; loopback has priority over tx_internal_active in every state:
  - LISTEN: rx_to_core <= filtered RX. loopback → LOOP; else tx_internal_active → TX.
  - TX: rx_to_core <= 0. loopback → LOOP. tx_internal_active low → GUARD with counter = TURNAROUND_CLOCKS-1, or → LISTEN if TURNAROUND_CLOCKS=0.
  - GUARD: rx_to_core <= 0; counter decrements. loopback → LOOP. tx_internal_active → TX (counter abandoned). Counter 0 → LISTEN.
  - LOOP: rx_to_core <= tx_internal. loopback low → GUARD (same load/skip rule as TX exit) so residual line activity is blanked.
- Total blanking after TX ends: exactly TURNAROUND_CLOCKS cycles of GUARD.
- Filter state keeps running in all states, so LISTEN sees the current line level immediately.
- irq = |(irq_status & ~irq_mask), registered.
- irq_mask does not affect irq_status.

Optional Feature:
- Macro: COAX_LINE_FRONTEND_LATCHED_IRQ_EN.
- Defined:
  - irq_status[i] sets on the rising edge of (rx_core_active[i] | rx_core_error[i]), detected with one registered copy.
  - It holds until irq_clear[i].
  - If set and clear occur in the same cycle, set wins.
- Not defined:
  - irq_status[i] is the registered level (rx_core_active[i] | rx_core_error[i]).
  - irq_clear is ignored.
- irq formula is identical in both cases.

Test Plan:
- Glitch filter: CHANNELS=1, defaults, idle line. Drive rx_pin high for 2 cycles → rx_to_core stays 0. Drive high for 10 cycles → rx_to_core rises exactly 2+3+1=6 cycles after the pin edge.
- Turnaround guard: tx_internal_active high 20 cycles while rx_pin toggles → rx_to_core 0 throughout TX. After the fall, 0 for exactly 32 cycles, then follows filtered RX.
- Re-transmit and bypass: tx_internal_active re-asserts at guard cycle 10 → state TX, tx_active_out 1 same cycle. Deassert → a fresh full 32-cycle guard. Repeat with TURNAROUND_CLOCKS=0 → RX resumes the cycle after TX ends.
- Loopback: loopback=1 with tx_internal pattern 1,0,1,1 and tx_internal_active=1 → tx_active_out 0; rx_to_core reproduces the pattern delayed 1 cycle; rx_pin ignored. Loopback and tx_internal_active rising together from LISTEN → LOOP.
- Multi-channel IRQ: CHANNELS=4, macro defined, mask=4'b0010. Pulse rx_core_error[1] → irq_status=4'b0010, irq 0. Pulse rx_core_active[2] → irq 1. irq_clear[2] coincident with a new rising edge on channel 2 → status bit stays 1. Clear alone → irq 0.
- Reset mid-guard: assert reset at guard cycle 5 → rx_to_core and irq 0 with no clock edge. On release, state LISTEN and rx_to_core follows the line after sync+filter latency.

Source files
------------

// File: rtl/coax_line_frontend.sv
//==========================================================================
// Module   : coax_line_frontend
// Purpose  : Per-channel coax RX sync/deglitch, TX turnaround blanking,
//            loopback select and maskable RX interrupt aggregation.
// Option   : COAX_LINE_FRONTEND_LATCHED_IRQ_EN - edge-latched irq_status
// Revision : 1.0 - initial release
//==========================================================================
`default_nettype none

module coax_line_frontend #(
   parameter int CHANNELS          = 1,
   parameter int SYNC_STAGES       = 2,
   parameter int FILTER_LENGTH     = 3,
   parameter int TURNAROUND_CLOCKS = 32
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [CHANNELS-1:0] rx_pin,
   input  logic [CHANNELS-1:0] tx_internal,
   input  logic [CHANNELS-1:0] tx_internal_active,
   input  logic [CHANNELS-1:0] loopback,
   output logic [CHANNELS-1:0] rx_to_core,
   output logic [CHANNELS-1:0] tx_active_out,
   input  logic [CHANNELS-1:0] rx_core_active,
   input  logic [CHANNELS-1:0] rx_core_error,
   input  logic [CHANNELS-1:0] irq_mask,
   input  logic [CHANNELS-1:0] irq_clear,
   output logic [CHANNELS-1:0] irq_status,
   output logic                irq
);

   localparam int c_fcnt_w = $clog2(FILTER_LENGTH) + 1;
   localparam int c_gcnt_w = (TURNAROUND_CLOCKS > 1) ? $clog2(TURNAROUND_CLOCKS) : 1;

   localparam logic [c_fcnt_w-1:0] c_filt_last  = c_fcnt_w'(FILTER_LENGTH - 1);
   localparam logic [c_gcnt_w-1:0] c_guard_load =
      (TURNAROUND_CLOCKS > 0) ? c_gcnt_w'(TURNAROUND_CLOCKS - 1) : '0;

   localparam logic [1:0] c_st_listen = 2'd0;
   localparam logic [1:0] c_st_tx     = 2'd1;
   localparam logic [1:0] c_st_guard  = 2'd2;
   localparam logic [1:0] c_st_loop   = 2'd3;

   // With no turnaround guard, leaving TX or LOOP goes straight back to listening
   localparam logic [1:0] c_st_release = (TURNAROUND_CLOCKS == 0) ? c_st_listen : c_st_guard;

   logic r_irq;

   genvar g;
   generate
      for (g = 0; g < CHANNELS; g++) begin : g_chan
         logic [SYNC_STAGES-1:0] r_sync;
         logic                   r_filt;
         logic [c_fcnt_w-1:0]    r_fcnt;
         logic [1:0]             r_state;
         logic [1:0]             w_state_nxt;
         logic [c_gcnt_w-1:0]    r_gcnt;
         logic [c_gcnt_w-1:0]    w_gcnt_nxt;
         logic                   r_rx;
         logic                   w_rx_sel;
         logic                   w_synced;
         logic                   w_event;
         logic                   r_status;

         assign w_synced = r_sync[SYNC_STAGES-1];
         assign w_event  = rx_core_active[g] | rx_core_error[g];

         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               r_sync <= '0;
               r_filt <= 1'b0;
               r_fcnt <= '0;
            end else begin
               r_sync <= {r_sync[SYNC_STAGES-2:0], rx_pin[g]};
               if (w_synced == r_filt) begin
                  r_fcnt <= '0;
               end else if (r_fcnt == c_filt_last) begin
                  r_filt <= w_synced;
                  r_fcnt <= '0;
               end else begin
                  r_fcnt <= r_fcnt + c_fcnt_w'(1);
               end
            end
         end

         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               r_state <= c_st_listen;
               r_gcnt  <= '0;
               r_rx    <= 1'b0;
            end else begin
               r_state <= w_state_nxt;
               r_gcnt  <= w_gcnt_nxt;
               r_rx    <= w_rx_sel;
            end
         end

         // Loopback overrides TX activity in every state
         always_comb begin
            w_state_nxt = r_state;
            w_gcnt_nxt  = r_gcnt;
            if (loopback[g]) begin
               w_state_nxt = c_st_loop;
            end else begin
               case (r_state)
                  c_st_listen: begin
                     if (tx_internal_active[g]) w_state_nxt = c_st_tx;
                  end
                  c_st_tx: begin
                     if (!tx_internal_active[g]) begin
                        w_state_nxt = c_st_release;
                        w_gcnt_nxt  = c_guard_load;
                     end
                  end
                  c_st_guard: begin
                     if (tx_internal_active[g]) begin
                        w_state_nxt = c_st_tx;
                     end else if (r_gcnt == '0) begin
                        w_state_nxt = c_st_listen;
                     end else begin
                        w_gcnt_nxt = r_gcnt - c_gcnt_w'(1);
                     end
                  end
                  c_st_loop: begin
                     w_state_nxt = c_st_release;
                     w_gcnt_nxt  = c_guard_load;
                  end
                  default: w_state_nxt = c_st_listen;
               endcase
            end
         end

         always_comb begin
            w_rx_sel = 1'b0;
            case (r_state)
               c_st_listen: w_rx_sel = r_filt;
               c_st_loop:   w_rx_sel = tx_internal[g];
               default:     w_rx_sel = 1'b0;
            endcase
         end

`ifdef COAX_LINE_FRONTEND_LATCHED_IRQ_EN
         logic r_event_d;

         // A fresh rising edge beats a coincident clear
         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               r_event_d <= 1'b0;
               r_status  <= 1'b0;
            end else begin
               r_event_d <= w_event;
               if (w_event && !r_event_d) begin
                  r_status <= 1'b1;
               end else if (irq_clear[g]) begin
                  r_status <= 1'b0;
               end
            end
         end
`else
         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               r_status <= 1'b0;
            end else begin
               r_status <= w_event;
            end
         end
`endif

         assign rx_to_core[g]    = r_rx;
         assign tx_active_out[g] = tx_internal_active[g] & ~loopback[g];
         assign irq_status[g]    = r_status;
      end
   endgenerate

`ifndef COAX_LINE_FRONTEND_LATCHED_IRQ_EN
   logic w_unused_irq_clear;
   assign w_unused_irq_clear = ^irq_clear;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_irq <= 1'b0;
      end else begin
         r_irq <= |(irq_status & ~irq_mask);
      end
   end

   assign irq = r_irq;

endmodule

`default_nettype wire

// File: tb/tb_coax_line_frontend.sv
//==========================================================================
// Module   : tb_coax_line_frontend
// Purpose  : Self-checking bench for coax_line_frontend (4-channel default
//            instance plus a 1-channel no-guard, single-sample-filter one).
// Revision : 1.0 - initial release
//==========================================================================
`default_nettype none

module tb_coax_line_frontend;

`ifdef COAX_LINE_FRONTEND_LATCHED_IRQ_EN
   localparam bit LATCHED = 1'b1;
`else
   localparam bit LATCHED = 1'b0;
`endif

   localparam int MODE_LINE  = 0;
   localparam int MODE_TX    = 1;
   localparam int MODE_BLANK = 2;
   localparam int MODE_LOOP  = 3;

   logic       clk   = 1'b0;
   logic       reset = 1'b0;
   logic [4:0] rx_pin = '0;
   logic [4:0] txi    = '0;
   logic [4:0] txa    = '0;
   logic [4:0] lb     = '0;
   logic [4:0] rca    = '0;
   logic [4:0] rce    = '0;
   logic [4:0] mask   = '0;
   logic [4:0] clr    = '0;
   logic [4:0] rx_out;
   logic [4:0] txo;
   logic [4:0] st;
   logic [1:0] irq_v;

   int total = 0;
   int bad   = 0;

   // Lanes 0..3 belong to dut_a, lane 4 to dut_b
   int c_sync [5] = '{2, 2, 2, 2, 3};
   int c_flen [5] = '{3, 3, 3, 3, 1};
   int c_turn [5] = '{32, 32, 32, 32, 0};

   int          m_mode [5];
   int          m_left [5];
   logic [15:0] m_hist [5];
   logic [4:0]  m_filt;
   logic [4:0]  m_rx;
   logic [4:0]  m_status;
   logic [4:0]  m_prev;
   logic [1:0]  m_irq;

   always #5 clk = ~clk;

   coax_line_frontend #(.CHANNELS(4)) dut_a (
      .clk                (clk),
      .reset              (reset),
      .rx_pin             (rx_pin[3:0]),
      .tx_internal        (txi[3:0]),
      .tx_internal_active (txa[3:0]),
      .loopback           (lb[3:0]),
      .rx_to_core         (rx_out[3:0]),
      .tx_active_out      (txo[3:0]),
      .rx_core_active     (rca[3:0]),
      .rx_core_error      (rce[3:0]),
      .irq_mask           (mask[3:0]),
      .irq_clear          (clr[3:0]),
      .irq_status         (st[3:0]),
      .irq                (irq_v[0])
   );

   coax_line_frontend #(
      .CHANNELS(1), .SYNC_STAGES(3), .FILTER_LENGTH(1), .TURNAROUND_CLOCKS(0)
   ) dut_b (
      .clk                (clk),
      .reset              (reset),
      .rx_pin             (rx_pin[4:4]),
      .tx_internal        (txi[4:4]),
      .tx_internal_active (txa[4:4]),
      .loopback           (lb[4:4]),
      .rx_to_core         (rx_out[4:4]),
      .tx_active_out      (txo[4:4]),
      .rx_core_active     (rca[4:4]),
      .rx_core_error      (rce[4:4]),
      .irq_mask           (mask[4:4]),
      .irq_clear          (clr[4:4]),
      .irq_status         (st[4:4]),
      .irq                (irq_v[1])
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int l = 0; l < 5; l++) begin
         m_mode[l] = MODE_LINE;
         m_left[l] = 0;
         m_hist[l] = '0;
      end
      m_filt   = '0;
      m_rx     = '0;
      m_status = '0;
      m_prev   = '0;
      m_irq    = '0;
   endtask

   // One clock edge of the reference: line level accepted once it has been
   // seen for FILTER_LENGTH samples, blanking counted as whole guard cycles.
   task automatic model_edge();
      logic [4:0] st_old;
      st_old   = m_status;
      m_irq[0] = |(st_old[3:0] & ~mask[3:0]);
      m_irq[1] = st_old[4] & ~mask[4];
      for (int l = 0; l < 5; l++) begin
         logic run;
         logic ev;
         case (m_mode[l])
            MODE_LINE: m_rx[l] = m_filt[l];
            MODE_LOOP: m_rx[l] = txi[l];
            default:   m_rx[l] = 1'b0;
         endcase
         if (lb[l]) begin
            m_mode[l] = MODE_LOOP;
         end else if (m_mode[l] == MODE_LINE) begin
            if (txa[l]) m_mode[l] = MODE_TX;
         end else if (m_mode[l] == MODE_BLANK) begin
            if (txa[l]) m_mode[l] = MODE_TX;
            else if (m_left[l] <= 1) m_mode[l] = MODE_LINE;
            else m_left[l] = m_left[l] - 1;
         end else if (m_mode[l] == MODE_LOOP || !txa[l]) begin
            m_left[l] = c_turn[l];
            m_mode[l] = (c_turn[l] == 0) ? MODE_LINE : MODE_BLANK;
         end
         run = 1'b1;
         for (int k = 0; k < c_flen[l]; k++)
            if (m_hist[l][c_sync[l] - 1 + k] == m_filt[l]) run = 1'b0;
         if (run) m_filt[l] = ~m_filt[l];
         m_hist[l] = {m_hist[l][14:0], rx_pin[l]};
         ev = rca[l] | rce[l];
         if (LATCHED) begin
            if (ev && !m_prev[l]) m_status[l] = 1'b1;
            else if (clr[l]) m_status[l] = 1'b0;
         end else begin
            m_status[l] = ev;
         end
         m_prev[l] = ev;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
      check("rx_to_core", 32'(rx_out), 32'(m_rx));
      check("tx_active_out", 32'(txo), 32'(txa & ~lb));
      check("irq_status", 32'(st), 32'(m_status));
      check("irq", 32'(irq_v), 32'(m_irq));
   endtask

   initial begin
      logic [3:0] pat;
      model_reset();
      #1 reset = 1'b1;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      check("reset_rx", 32'(rx_out), 0);
      check("reset_status", 32'(st), 0);
      check("reset_irq", 32'(irq_v), 0);

      // Glitch shorter than the filter, then a stable edge
      rx_pin[0] = 1'b1; rx_pin[4] = 1'b1;
      repeat (2) begin tick(); check("glitch_a", 32'(rx_out[0]), 0); end
      rx_pin[0] = 1'b0; rx_pin[4] = 1'b0;
      repeat (8) begin tick(); check("glitch_a", 32'(rx_out[0]), 0); end
      rx_pin[0] = 1'b1; rx_pin[4] = 1'b1;
      for (int n = 1; n <= 10; n++) begin
         tick();
         check("latency_a", 32'(rx_out[0]), 32'(n >= 6));
         check("latency_b", 32'(rx_out[4]), 32'(n >= 5));
      end
      rx_pin[0] = 1'b0; rx_pin[4] = 1'b0;
      repeat (10) tick();

      // Blanking during TX and the turnaround guard afterwards
      txa[0] = 1'b1; txa[4] = 1'b1;
      for (int n = 1; n <= 20; n++) begin
         rx_pin[0] = (n <= 12) ? 1'($urandom_range(1)) : 1'b1;
         rx_pin[4] = rx_pin[0];
         tick();
         check("tx_blank_a", 32'(rx_out[0]), 0);
         check("tx_blank_b", 32'(rx_out[4]), 0);
      end
      txa[0] = 1'b0; txa[4] = 1'b0;
      for (int n = 1; n <= 40; n++) begin
         tick();
         check("guard_a", 32'(rx_out[0]), 32'(n >= 34));
         check("no_guard_b", 32'(rx_out[4]), 32'(n >= 2));
      end

      // Re-transmit in the middle of the guard restarts it in full
      txa[0] = 1'b1;
      repeat (3) tick();
      txa[0] = 1'b0;
      repeat (10) tick();
      txa[0] = 1'b1;
      #1 check("retx_comb", 32'(txo[0]), 1);
      repeat (3) tick();
      txa[0] = 1'b0;
      for (int n = 1; n <= 40; n++) begin
         tick();
         check("reguard_a", 32'(rx_out[0]), 32'(n >= 34));
      end

      // Loopback entered together with TX activity
      lb[1] = 1'b1; txa[1] = 1'b1; lb[4] = 1'b1; txa[4] = 1'b1;
      #1 check("loop_txo", 32'({txo[4], txo[1]}), 0);
      tick();
      pat = 4'b1101;
      for (int j = 0; j < 4; j++) begin
         txi[1] = pat[j]; txi[4] = pat[j]; rx_pin[1] = ~pat[j];
         tick();
         check("loop_a", 32'(rx_out[1]), 32'(pat[j]));
         check("loop_b", 32'(rx_out[4]), 32'(pat[j]));
      end
      lb = '0; txa = '0; txi = '0; rx_pin[1] = 1'b0;
      repeat (40) tick();

      // Interrupt status, masking and clear
      mask = 5'b00010;
      rce[1] = 1'b1; tick(); rce[1] = 1'b0; tick();
      check("irq_st_err", 32'(st[3:0]), LATCHED ? 32'h2 : 32'h0);
      check("irq_masked", 32'(irq_v[0]), 0);
      rca[2] = 1'b1; tick(); rca[2] = 1'b0; tick();
      check("irq_unmasked", 32'(irq_v[0]), 1);
      clr[2] = 1'b1; rca[2] = 1'b1; tick();
      check("set_wins", 32'(st[2]), 1);
      clr = '0; rca = '0; tick();
      clr[2] = 1'b1; clr[1] = 1'b1; tick();
      clr = '0; tick();
      check("irq_cleared", 32'(irq_v[0]), 0);
      check("status_cleared", 32'(st[3:0]), 0);

      // Reset in the middle of a guard
      rx_pin[3] = 1'b1; rca[3] = 1'b1;
      repeat (8) tick();
      txa[0] = 1'b1; repeat (2) tick();
      txa[0] = 1'b0; repeat (5) tick();
      check("pre_rst_irq", 32'(irq_v[0]), 1);
      check("pre_rst_rx", 32'(rx_out[3]), 1);
      reset = 1'b1;
      #2;
      check("rst_rx", 32'(rx_out), 0);
      check("rst_irq", 32'(irq_v), 0);
      check("rst_status", 32'(st), 0);
      model_reset();
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      for (int n = 1; n <= 8; n++) begin
         tick();
         check("post_rst_a0", 32'(rx_out[0]), 32'(n >= 6));
         check("post_rst_a3", 32'(rx_out[3]), 32'(n >= 6));
         check("post_rst_b", 32'(rx_out[4]), 32'(n >= 5));
      end
      rca = '0;

      // Randomised traffic against the reference
      for (int i = 0; i < 800; i++) begin
         for (int l = 0; l < 5; l++) begin
            if ($urandom_range(3) == 0) rx_pin[l] = ~rx_pin[l];
            txi[l] = 1'($urandom_range(1));
            if ($urandom_range(15) == 0) txa[l] = ~txa[l];
            if ($urandom_range(40) == 0) lb[l] = ~lb[l];
            rca[l] = ($urandom_range(9) == 0);
            rce[l] = ($urandom_range(19) == 0);
            clr[l] = ($urandom_range(5) == 0);
         end
         if ($urandom_range(31) == 0) mask = 5'($urandom);
         tick();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
